// File: rtl/alu_arbiter_if.sv
// Bundle for alu_arbiter: two request/response channels plus the shared ALU ports.
// The slave modport is the arbiter; the master modport is its environment, including the ALU.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_op;

  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp0_zero;
  logic        rsp0_err;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;
  logic        rsp1_zero;
  logic        rsp1_err;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared ALU: IDLE -> EXEC -> RESP, one operation in flight.
// Define ALU_ARB_RR_EN for round-robin grants; otherwise requester 0 has fixed priority.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b1001, 4'b1010, 4'b1011: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  state_t             state;
  logic               gnt0, gnt1;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [OP_W-1:0]    sel_op;

  logic               gnt_id_p0;
  logic               err_p0;
  logic [DATA_W-1:0]  alu_a_p0, alu_b_p0;
  logic [OP_W-1:0]    alu_ctrl_p0;

  logic [DATA_W-1:0]  result_p1;
  logic               zero_p1, err_p1;
  logic               vld0_p1, vld1_p1;

`ifdef ALU_ARB_RR_EN
  logic ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end
`else
  always_comb begin
    gnt0 = (state == IDLE) && bus.req0_valid;
    gnt1 = (state == IDLE) && bus.req1_valid && !bus.req0_valid;
  end
`endif

  always_comb begin
    sel_a  = gnt1 ? bus.req1_a  : bus.req0_a;
    sel_b  = gnt1 ? bus.req1_b  : bus.req0_b;
    sel_op = gnt1 ? bus.req1_op : bus.req0_op;
  end

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.alu_a       = alu_a_p0;
  assign bus.alu_b       = alu_b_p0;
  assign bus.alu_ctrl    = alu_ctrl_p0;
  assign bus.rsp0_valid  = vld0_p1;
  assign bus.rsp1_valid  = vld1_p1;
  assign bus.rsp0_result = result_p1;
  assign bus.rsp1_result = result_p1;
  assign bus.rsp0_zero   = zero_p1;
  assign bus.rsp1_zero   = zero_p1;
  assign bus.rsp0_err    = err_p1;
  assign bus.rsp1_err    = err_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_id_p0   <= 1'b0;
      err_p0      <= 1'b0;
      alu_a_p0    <= '0;
      alu_b_p0    <= '0;
      alu_ctrl_p0 <= '0;
      result_p1   <= '0;
      zero_p1     <= 1'b0;
      err_p1      <= 1'b0;
      vld0_p1     <= 1'b0;
      vld1_p1     <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr         <= 1'b0;
`endif
    end else begin
      case (state)
        // p0: accept request; illegal codes keep the ALU ports parked at 0/ADD
        IDLE: begin
          if (gnt0 || gnt1) begin
            gnt_id_p0 <= gnt1;
            err_p0    <= !is_legal_op(sel_op);
            if (is_legal_op(sel_op)) begin
              alu_a_p0    <= sel_a;
              alu_b_p0    <= sel_b;
              alu_ctrl_p0 <= sel_op;
            end else begin
              alu_a_p0    <= '0;
              alu_b_p0    <= '0;
              alu_ctrl_p0 <= '0;
            end
`ifdef ALU_ARB_RR_EN
            ptr <= gnt0;
`endif
            state <= EXEC;
          end
        end
        // p1: capture the ALU result and release the ALU
        EXEC: begin
          result_p1   <= err_p0 ? '0   : bus.alu_result;
          zero_p1     <= err_p0 ? 1'b0 : bus.alu_zero;
          err_p1      <= err_p0;
          vld0_p1     <= !gnt_id_p0;
          vld1_p1     <= gnt_id_p0;
          alu_a_p0    <= '0;
          alu_b_p0    <= '0;
          alu_ctrl_p0 <= '0;
          state       <= RESP;
        end
        RESP: begin
          if ((vld0_p1 && bus.rsp0_ready) || (vld1_p1 && bus.rsp1_ready)) begin
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the shared ports.
// Grant-order expectations follow ALU_ARB_RR_EN when the bench is built with it.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] alu_r;
  always_comb begin
    alu_r = '0;
    case (bus.alu_ctrl)
      4'b0000: alu_r = bus.alu_a + bus.alu_b;
      4'b0001: alu_r = bus.alu_a - bus.alu_b;
      4'b0010: alu_r = bus.alu_a & bus.alu_b;
      4'b0100: alu_r = bus.alu_a | bus.alu_b;
      4'b1000: alu_r = bus.alu_a ^ bus.alu_b;
      4'b1001: alu_r = bus.alu_a >> bus.alu_b[4:0];
      4'b1010: alu_r = bus.alu_a << bus.alu_b[4:0];
      4'b1011: alu_r = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      default: alu_r = '0;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = (alu_r == 32'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.req0_valid = v;
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_op    = op;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.req1_valid = v;
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_op    = op;
  endtask

  logic exp_gnt[4];

  initial begin
    set_req0(1'b0, 32'd0, 32'd0, 4'd0);
    set_req1(1'b0, 32'd0, 32'd0, 4'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    check("rst_result", bus.rsp0_result, 32'd0);
    check("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    rst = 1'b0;
    tick();

    // req0 SUB 5-3
    set_req0(1'b1, 32'd5, 32'd3, 4'b0001);
    #1;
    check("sub_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    check("sub_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    check("sub_exec_ctrl", {28'd0, bus.alu_ctrl}, 32'd1);
    check("sub_exec_a", bus.alu_a, 32'd5);
    check("sub_exec_b", bus.alu_b, 32'd3);
    check("sub_exec_rsp_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    tick();
    check("sub_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    check("sub_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    check("sub_result", bus.rsp0_result, 32'd2);
    check("sub_zero", {31'd0, bus.rsp0_zero}, 32'd0);
    check("sub_err", {31'd0, bus.rsp0_err}, 32'd0);
    check("sub_resp_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    check("sub_done_valid", {31'd0, bus.rsp0_valid}, 32'd0);

    // req1 XOR 7^7 with a stalled consumer, req0 waiting behind it
    set_req1(1'b1, 32'd7, 32'd7, 4'b1000);
    #1;
    check("xor_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    set_req0(1'b1, 32'd1, 32'd2, 4'b0000);
    #1;
    check("xor_exec_ctrl", {28'd0, bus.alu_ctrl}, 32'd8);
    check("xor_exec_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("xor_hold_valid", {31'd0, bus.rsp1_valid}, 32'd1);
      check("xor_hold_result", bus.rsp1_result, 32'd0);
      check("xor_hold_zero", {31'd0, bus.rsp1_zero}, 32'd1);
      check("xor_hold_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
      check("xor_hold_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
      check("xor_hold_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
    #1;
    check("xor_done_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    check("add_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    check("add_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    check("add_result", bus.rsp0_result, 32'd3);
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;

    // illegal op 0011
    set_req0(1'b1, 32'd9, 32'd4, 4'b0011);
    #1;
    check("ill_ready", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    check("ill_exec_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    check("ill_exec_a", bus.alu_a, 32'd0);
    tick();
    check("ill_rsp_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    check("ill_err", {31'd0, bus.rsp0_err}, 32'd1);
    check("ill_result", bus.rsp0_result, 32'd0);
    check("ill_zero", {31'd0, bus.rsp0_zero}, 32'd0);
    check("ill_resp_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;

    // reset while EXEC drops the operation
    set_req0(1'b1, 32'd1, 32'd1, 4'b0000);
    tick();
    bus.req0_valid = 1'b0;
    check("rst_exec_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_drop_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
      check("rst_drop_rsp1", {31'd0, bus.rsp1_valid}, 32'd0);
      tick();
    end
    set_req0(1'b1, 32'h8000_0000, 32'd4, 4'b1011);
    #1;
    check("sra_ready", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    check("sra_rsp_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    check("sra_result", bus.rsp0_result, 32'hF800_0000);
    check("sra_err", {31'd0, bus.rsp0_err}, 32'd0);
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;

    // both valid every opportunity, starting from a fresh reset
`ifdef ALU_ARB_RR_EN
    exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_gnt = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req0(1'b1, 32'd10, 32'd1, 4'b0000);
    set_req1(1'b1, 32'd10, 32'd1, 4'b0001);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("arb_req0_ready", {31'd0, bus.req0_ready}, {31'd0, !exp_gnt[i]});
      check("arb_req1_ready", {31'd0, bus.req1_ready}, {31'd0, exp_gnt[i]});
      tick();
      check("arb_exec_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
      tick();
      check("arb_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid},
            exp_gnt[i] ? 32'd2 : 32'd1);
      check("arb_result", bus.rsp0_result, exp_gnt[i] ? 32'd9 : 32'd11);
      tick();
    end
    set_req0(1'b0, 32'd0, 32'd0, 4'd0);
    set_req1(1'b0, 32'd0, 32'd0, 4'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    tick();
    check("end_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
